// File: rtl/bus_initiator.sv
// bus_initiator: master end of an 8086-style T1/T2/T3/(Tw)/T4 memory/IO bus.
// Takes single read/write requests from an internal client, runs one bus
// cycle per request, and returns read data or a done/err pulse.
//
// Ports:
//   clk, rst          clock (posedge) and synchronous active-low reset
//   req, req_wr, req_io, req_addr, req_wdata
//                     client request, accepted when req & req_ready
//   req_ready         initiator can take a request this cycle (IDLE, T4)
//   done, err, rdata  completion pulse, timeout flag, captured read data
//   Address, ALE, RD, WR, M_IO, Data_out, Data_oe
//                     bus side outputs (RD/WR active-low)
//   Data_in, READY    bus read data and responder ready (low = wait)
//
// All outputs are flops loaded from values decoded out of the next state and
// the next captured request, so they line up exactly with the state register.
module bus_initiator #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_wr,
  input  logic              req_io,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] Address,
  output logic              ALE,
  output logic              RD,
  output logic              WR,
  output logic              M_IO,
  output logic [DATA_W-1:0] Data_out,
  output logic              Data_oe,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              READY
);

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_T1   = 6'b000010,
    S_T2   = 6'b000100,
    S_T3   = 6'b001000,
    S_TW   = 6'b010000,
    S_T4   = 6'b100000
  } state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                tmo_q, tmo_d;
  logic                cap_wr_q, cap_wr_d;
  logic                cap_io_q, cap_io_d;
  logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0]   cap_wdata_q, cap_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [ADDR_W-1:0]   address_q, address_d;
  logic                ale_q, ale_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                m_io_q, m_io_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                data_oe_q, data_oe_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                req_ready_q, req_ready_d;

  logic                accept_s;
  logic                strobe_s;
  logic                bus_s;

  // Next-state, capture and output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    rdata_d     = rdata_q;
    cap_wr_d    = cap_wr_q;
    cap_io_d    = cap_io_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;

    // req_ready_q is the value the client sees this cycle.
    accept_s = req & req_ready_q;

    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = S_T1;
        else          state_d = S_IDLE;
      end
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: begin
        if (READY) begin
          state_d = S_T4;
          if (!cap_wr_q) rdata_d = Data_in;
          else           rdata_d = rdata_q;
        end else begin
          state_d = S_TW;
          cnt_d   = 8'd1;
        end
      end
      S_TW: begin
        if (READY) begin
          state_d = S_T4;
          cnt_d   = 8'd0;
          if (!cap_wr_q) rdata_d = Data_in;
          else           rdata_d = rdata_q;
        end else if (cnt_q < MAX_WAIT_C) begin
          state_d = S_TW;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          // Watchdog expired: close the cycle without touching rdata.
          state_d = S_T4;
          cnt_d   = 8'd0;
          tmo_d   = 1'b1;
        end
      end
      S_T4: begin
        tmo_d = 1'b0;
        if (accept_s) state_d = S_T1;
        else          state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        tmo_d   = 1'b0;
      end
    endcase

    if (accept_s) begin
      cap_wr_d    = req_wr;
      cap_io_d    = req_io;
      cap_addr_d  = req_addr;
      cap_wdata_d = req_wdata;
    end else begin
      cap_wr_d    = cap_wr_q;
      cap_io_d    = cap_io_q;
      cap_addr_d  = cap_addr_q;
      cap_wdata_d = cap_wdata_q;
    end

    // Moore decode against the state the flops will hold next cycle.
    bus_s    = (state_d != S_IDLE);
    strobe_s = (state_d == S_T2) || (state_d == S_T3) || (state_d == S_TW);

    address_d   = bus_s ? cap_addr_d : {ADDR_W{1'b0}};
    m_io_d      = bus_s & cap_io_d;
    ale_d       = (state_d == S_T1);
    rd_d        = ~(strobe_s & ~cap_wr_d);
    wr_d        = ~(strobe_s & cap_wr_d);
    data_oe_d   = cap_wr_d & (strobe_s | (state_d == S_T4));
    data_out_d  = data_oe_d ? cap_wdata_d : {DATA_W{1'b0}};
    done_d      = (state_d == S_T4);
    err_d       = (state_d == S_T4) & tmo_d;
    req_ready_d = (state_d == S_IDLE) || (state_d == S_T4);
  end

  // State, capture and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      tmo_q       <= 1'b0;
      cap_wr_q    <= 1'b0;
      cap_io_q    <= 1'b0;
      cap_addr_q  <= {ADDR_W{1'b0}};
      cap_wdata_q <= {DATA_W{1'b0}};
      rdata_q     <= {DATA_W{1'b0}};
      address_q   <= {ADDR_W{1'b0}};
      ale_q       <= 1'b0;
      rd_q        <= 1'b1;
      wr_q        <= 1'b1;
      m_io_q      <= 1'b0;
      data_out_q  <= {DATA_W{1'b0}};
      data_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      cap_wr_q    <= cap_wr_d;
      cap_io_q    <= cap_io_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      rdata_q     <= rdata_d;
      address_q   <= address_d;
      ale_q       <= ale_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      m_io_q      <= m_io_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      done_q      <= done_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign Address   = address_q;
  assign ALE       = ale_q;
  assign RD        = rd_q;
  assign WR        = wr_q;
  assign M_IO      = m_io_q;
  assign Data_out  = data_out_q;
  assign Data_oe   = data_oe_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator. The reference model tracks each
// transfer as "cycle number c since acceptance" plus its planned wait count;
// every bus output is derived arithmetically from c, so no state machine of
// the design is re-expressed here.
module tb_bus_initiator;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          req, req_wr, req_io;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, done, err;
  logic [DW-1:0] rdata;
  logic [AW-1:0] Address;
  logic          ALE, RD, WR, M_IO;
  logic [DW-1:0] Data_out;
  logic          Data_oe;
  logic [DW-1:0] Data_in;
  logic          READY;

  bus_initiator #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_wr(req_wr), .req_io(req_io),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .done(done), .err(err), .rdata(rdata),
    .Address(Address), .ALE(ALE), .RD(RD), .WR(WR), .M_IO(M_IO),
    .Data_out(Data_out), .Data_oe(Data_oe), .Data_in(Data_in), .READY(READY)
  );

  always #5 clk = ~clk;

  // Reference model: one transfer described by its cycle index and wait plan.
  bit            m_inrst;
  bit            m_busy;
  int            m_cyc;
  int            m_weff;
  bit            m_tmo;
  bit            m_wr;
  bit            m_io;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock: check current outputs against the model, drive inputs for the
  // next edge, then advance the model across that edge.
  // w = number of READY=0 samples wanted from T3 on; w > MW means timeout.
  task automatic cycle(input bit rst_v, input bit rq, input bit wr, input bit io,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int w, input logic [DW-1:0] din);
    bit            act;
    bit            strobe;
    bit            e_rr, e_ale, e_rd, e_wr, e_mio, e_oe, e_done, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_dout;
    bit            ready_v;
    int            len;

    @(negedge clk);
    act    = m_busy && !m_inrst;
    len    = 4 + m_weff;
    strobe = act && (m_cyc >= 2) && (m_cyc <= 3 + m_weff);
    e_rr   = !m_inrst && (!m_busy || m_cyc == len);
    e_ale  = act && (m_cyc == 1);
    e_rd   = !(strobe && !m_wr);
    e_wr   = !(strobe && m_wr);
    e_mio  = act && m_io;
    e_addr = act ? m_addr : '0;
    e_oe   = act && m_wr && (m_cyc >= 2);
    e_dout = e_oe ? m_wdata : '0;
    e_done = act && (m_cyc == len);
    e_err  = e_done && m_tmo;

    check_eq("req_ready", 32'(req_ready), 32'(e_rr));
    check_eq("ALE",       32'(ALE),       32'(e_ale));
    check_eq("RD",        32'(RD),        32'(e_rd));
    check_eq("WR",        32'(WR),        32'(e_wr));
    check_eq("M_IO",      32'(M_IO),      32'(e_mio));
    check_eq("Address",   32'(Address),   32'(e_addr));
    check_eq("Data_oe",   32'(Data_oe),   32'(e_oe));
    check_eq("Data_out",  32'(Data_out),  32'(e_dout));
    check_eq("done",      32'(done),      32'(e_done));
    check_eq("err",       32'(err),       32'(e_err));
    check_eq("rdata",     32'(rdata),     32'(m_rdata));

    // READY follows the plan inside the T3..Tw sampling window, random elsewhere.
    if (act && m_cyc >= 3 && m_cyc <= 3 + m_weff)
      ready_v = (m_cyc == 3 + m_weff) && !m_tmo;
    else
      ready_v = 1'($urandom);

    rst       = rst_v;
    req       = rq;
    req_wr    = wr;
    req_io    = io;
    req_addr  = a;
    req_wdata = wd;
    Data_in   = din;
    READY     = ready_v;

    if (!rst_v) begin
      m_inrst = 1'b1;
      m_busy  = 1'b0;
      m_rdata = '0;
    end else begin
      if (act && m_cyc == 3 + m_weff && ready_v && !m_wr) m_rdata = din;
      if (act && m_cyc < len) begin
        m_cyc++;
      end else if (rq && e_rr) begin
        m_busy  = 1'b1;
        m_cyc   = 1;
        m_wr    = wr;
        m_io    = io;
        m_addr  = a;
        m_wdata = wd;
        m_tmo   = (w > MW);
        m_weff  = (w > MW) ? MW : w;
      end else begin
        m_busy = 1'b0;
      end
      m_inrst = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 0, DW'($urandom));
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; req_wr = 1'b0; req_io = 1'b0;
    req_addr = '0; req_wdata = '0; Data_in = '0; READY = 1'b1;
    m_inrst = 1'b1; m_busy = 1'b0; m_cyc = 0; m_weff = 0; m_tmo = 1'b0;
    m_wr = 1'b0; m_io = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    @(posedge clk);

    // Reset state
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 20'hFFFFF, 16'hFFFF, 0, 16'h0);
    idle_cycles(2);

    // Zero-wait memory read
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 20'hA5A5A, 16'h0, 0, 16'h1234);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 0, 16'h1234);
    check_eq("tp_read_rdata", 32'(rdata), 32'h1234);

    // IO write with two wait states
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 20'h00310, 16'hBEEF, 2, 16'h0);
    idle_cycles(8);

    // Timeout read: rdata must keep the previous read value
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 20'h12345, 16'h0, 20, 16'h0);
    idle_cycles(22);
    check_eq("tp_timeout_rdata", 32'(rdata), 32'h1234);

    // Longest legal wait (no timeout)
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 20'h0ABCD, 16'h0, MW, 16'h0);
    idle_cycles(22);

    // Back-to-back write then read with req held high through T4
    n_done = 0;
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 20'h11111, 16'hCAFE, 0, 16'h0);
    if (done) n_done++;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 20'h22222, 16'h0, 0, 16'h5A5A);
      if (done) n_done++;
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 0, 16'h5A5A);
      if (done) n_done++;
    end
    check_eq("tp_b2b_done_count", 32'(n_done), 32'd2);

    // Reset during a wait state of a write, then a normal read
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 20'h33333, 16'h7777, 6, 16'h0);
    idle_cycles(4);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 0, 16'h0);
    idle_cycles(2);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 20'h44444, 16'h0, 1, 16'h9999);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 0, 16'h9999);
    check_eq("tp_after_reset_rdata", 32'(rdata), 32'h9999);

    // Request pulsed during T2 is ignored
    n_done = 0;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 20'h55555, 16'h0, 0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 0, 16'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 20'h66666, 16'h1111, 0, 16'h0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 0, 16'h0);
      if (done) n_done++;
    end
    check_eq("tp_ignored_done_count", 32'(n_done), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int w;
      w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 3));
      cycle($urandom_range(0, 249) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
            AW'($urandom), DW'($urandom), w, DW'($urandom));
    end
    idle_cycles(25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
